// File: rtl/return_stack_pkg.sv
// Shared constants and control-transfer decode for the return address stack.
// Sizes here set the default geometry of return_stack and stack_ram.
package return_stack_pkg;

  localparam int RAS_DEPTH = 8;
  localparam int RAS_WIDTH = 32;

  function automatic int sp_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int RAS_SP_W = sp_w(RAS_DEPTH);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_SWAP
  } ras_op_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

  // Link-register hint table: a swap maps onto push&pop of the stack.
  function automatic ras_op_e ras_decode(
    input logic [6:0] opcode,
    input logic [4:0] rd,
    input logic [4:0] rs1
  );
    ras_op_e op;
    op = RAS_NONE;
    if (opcode == OP_JAL) begin
      if (is_link(rd)) op = RAS_PUSH;
    end else if (opcode == OP_JALR) begin
      if (is_link(rd) && is_link(rs1))
        op = (rd != rs1) ? RAS_SWAP : RAS_PUSH;
      else if (is_link(rd))
        op = RAS_PUSH;
      else if (is_link(rs1))
        op = RAS_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/return_stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module stack_ram
  import return_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int WIDTH = RAS_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_stack.sv
// Return address stack: upward-growing pointer, sticky error flags and
// a registered pop result one cycle after the pop is accepted.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int WIDTH = RAS_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [31:0]      sp,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int SP_W = sp_w(DEPTH);
  localparam int AW   = $clog2(DEPTH);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  logic [SP_W-1:0]  r_sp;
  logic             r_pop_valid;
  logic [WIDTH-1:0] r_pop_data;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;
  logic             w_flush;
  logic             w_swap;
  logic             w_push;
  logic             w_pop;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_rdata;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == SP_FULL);
  // At sp==DEPTH the low bits wrap to 0, so top index is still sp-1.
  assign w_wr_idx  = r_sp[AW-1:0];
  assign w_top_idx = w_wr_idx - AW'(1);

  assign w_flush = flush;
  assign w_swap  = !flush && push && pop;
  assign w_push  = !flush && push && !pop;
  assign w_pop   = !flush && pop && !push;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_wr_idx;
    unique case (1'b1)
      w_flush: begin
        w_we = 1'b0;
      end
      w_swap: begin
        w_we    = 1'b1;
        w_waddr = w_empty ? w_wr_idx : w_top_idx;
      end
      w_push: begin
        w_we = !w_full;
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  stack_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (push_data),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp        <= '0;
      r_pop_valid <= 1'b0;
      r_pop_data  <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      unique case (1'b1)
        w_flush: begin
          r_sp <= '0;
        end
        w_swap: begin
          if (w_empty) begin
            r_sp  <= SP_W'(1);
            r_unf <= 1'b1;
          end else begin
            r_pop_valid <= 1'b1;
            r_pop_data  <= w_rdata;
          end
        end
        w_push: begin
          if (w_full) r_ovf <= 1'b1;
          else        r_sp  <= r_sp + SP_W'(1);
        end
        w_pop: begin
          if (w_empty) begin
            r_unf <= 1'b1;
          end else begin
            r_sp        <= r_sp - SP_W'(1);
            r_pop_valid <= 1'b1;
            r_pop_data  <= w_rdata;
          end
        end
        default: begin
          r_sp <= r_sp;
        end
      endcase
    end
  end

  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign sp        = 32'(r_sp);
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_return_stack.sv
// Directed and random checks of return_stack against a queue-based
// stack model; expected pop results flow through a scoreboard queue.
module tb_return_stack;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [31:0]      sp;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  return_stack #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_stk[$];
  logic [31:0] m_last;
  bit          m_ovf;
  bit          m_unf;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit f, input bit pu, input bit po,
                       input logic [31:0] d);
    exp_t e;
    e.v = 1'b0;
    e.d = '0;
    if (f) begin
      m_stk.delete();
    end else if (pu && po) begin
      if (m_stk.size() > 0) begin
        e.v = 1'b1;
        e.d = m_stk[m_stk.size()-1];
        m_stk[m_stk.size()-1] = d;
      end else begin
        m_stk.push_back(d);
        m_unf = 1'b1;
      end
    end else if (pu) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(d);
      else m_ovf = 1'b1;
    end else if (po) begin
      if (m_stk.size() > 0) begin
        e.v = 1'b1;
        e.d = m_stk.pop_back();
      end else begin
        m_unf = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic check_state(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 64'(pop_valid), 64'(e.v));
    if (e.v) begin
      m_last = e.d;
      chk({tag, "_data"}, 64'(pop_data), 64'(e.d));
    end else begin
      chk({tag, "_hold"}, 64'(pop_data), 64'(m_last));
    end
    chk({tag, "_sp"}, 64'(sp), 64'(m_stk.size()));
    chk({tag, "_full"}, 64'(full), 64'(m_stk.size() == DEPTH));
    chk({tag, "_empty"}, 64'(empty), 64'(m_stk.size() == 0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, "_unf"}, 64'(underflow), 64'(m_unf));
  endtask

  task automatic step(input string tag, input bit f, input bit pu,
                      input bit po, input logic [31:0] d);
    flush     = f;
    push      = pu;
    pop       = po;
    push_data = d;
    model(f, pu, po, d);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    check_state(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sp"}, 64'(sp), 64'd0);
    chk({tag, "_valid"}, 64'(pop_valid), 64'd0);
    chk({tag, "_data"}, 64'(pop_data), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_unf"}, 64'(underflow), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
  endtask

  // Async reset asserted mid-cycle, checked before any clock edge.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m_stk.delete();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_last = '0;
    check_reset_vals(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    m_last    = '0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("p10", 0, 1, 0, 32'h10);
    step("p20", 0, 1, 0, 32'h20);
    step("p30", 0, 1, 0, 32'h30);
    step("o30", 0, 0, 1, 0);
    step("o20", 0, 0, 1, 0);
    step("o10", 0, 0, 1, 0);
    step("idle", 0, 0, 0, 0);

    for (int i = 1; i <= 9; i++) step("fill", 0, 1, 0, 32'(i));
    step("o8", 0, 0, 1, 0);
    step("flush", 1, 0, 0, 0);

    mid_reset("rst2");
    step("uf", 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("uf_stick", 0, 0, 0, 0);
    step("uf_flush", 1, 0, 0, 0);

    step("pA", 0, 1, 0, 32'hA);
    step("pB", 0, 1, 0, 32'hB);
    step("swapC", 0, 1, 1, 32'hC);
    step("oC", 0, 0, 1, 0);
    step("oA", 0, 0, 1, 0);

    for (int i = 0; i < 5; i++) step("to5", 0, 1, 0, 32'h50 + 32'(i));
    step("fl_push", 1, 1, 0, 32'h77);
    step("swap_mt", 0, 1, 1, 32'h99);
    step("o99", 0, 0, 1, 0);

    mid_reset("rst3");
    for (int i = 0; i < DEPTH; i++) step("fill8", 0, 1, 0, 32'hE0 + 32'(i));
    step("swap_full", 0, 1, 1, 32'hEE);
    step("oEE", 0, 0, 1, 0);
    step("o_e6", 0, 0, 1, 0);

    step("p55", 0, 1, 0, 32'h55);
    step("p66", 0, 1, 0, 32'h66);
    step("o66", 0, 0, 1, 0);
    mid_reset("rst_pop");
    step("post_rst", 0, 0, 0, 0);
    step("post_rst2", 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      automatic int r = int'($urandom_range(0, 99));
      automatic bit f = (r < 4);
      automatic bit pu = ($urandom_range(0, 1) == 1);
      automatic bit po = ($urandom_range(0, 1) == 1);
      step("rnd", f, pu, po, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of stack entries (power of two, 2..64).
REQ-002 SHALL have parameter WIDTH, default 32, width of each stored entry.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous clear of all entries.
REQ-006 SHALL have port push  input  1  request to store push_data on top of stack.
REQ-007 SHALL have port pop  input  1  request to remove and return top entry.
REQ-008 SHALL have port push_data  input  WIDTH  value to store, e.g. a return address.
REQ-009 SHALL have port pop_data  output  WIDTH  popped value, valid only while pop_valid=1.
REQ-010 SHALL have port pop_valid  output  1  one-cycle strobe marking pop_data valid.
REQ-011 SHALL have port sp  output  32  current entry count, zero-extended.
REQ-012 SHALL have port full  output  1  combinational, sp==DEPTH.
REQ-013 SHALL have port empty  output  1  combinational, sp==0.
REQ-014 SHALL have port overflow  output  1  sticky: a push was refused.
REQ-015 SHALL have port underflow  output  1  sticky: a pop was refused.

Function
REQ-016 SHALL grow upward: sp = number of valid entries; top entry held at index sp-1.
REQ-017 SHALL treat priority per edge as: flush > push&pop > push > pop.
REQ-018 SHALL, on flush, set sp=0, pop_valid=0 next cycle, and ignore push/pop that cycle; the overflow and underflow flags are unchanged.
REQ-019 SHALL, on push alone with sp<DEPTH, write push_data at index sp and increment sp.
REQ-020 SHALL, on push alone with sp==DEPTH, leave memory and sp unchanged and set overflow.
REQ-021 SHALL, on pop alone with sp>0, decrement sp, and on the next cycle drive pop_valid=1 with pop_data = the old top entry (latency 1).
REQ-022 SHALL, on pop alone with sp==0, leave sp unchanged, keep pop_valid=0, and set underflow.
REQ-023 SHALL, on push&pop with sp>0, return the old top next cycle (pop_valid=1) and overwrite index sp-1 with push_data; sp is unchanged, full or not, and there is no overflow.
REQ-024 SHALL, on push&pop with sp==0, perform the push only (sp becomes 1), keep pop_valid=0, and set underflow.
REQ-025 SHALL hold pop_data registered at its last popped value when pop_valid=0.
REQ-026 SHALL never let sp leave the range 0..DEPTH.
REQ-027 SHALL accept back-to-back operations every cycle, with no stall and no ready signal.

Reset
REQ-028 SHALL, with reset low, asynchronously force sp=0, pop_valid=0, pop_data=0, overflow=0 and underflow=0.
REQ-029 SHALL NOT reset stack memory contents; entries are unreachable while sp=0.
REQ-030 SHALL, on reset asserted mid-operation, abandon any pending pop_valid and leave no stale strobe after release.

Structure
REQ-031 SHALL take DEPTH, WIDTH and SP_W=$clog2(DEPTH)+1 from the shared package constants, alongside the instruction-type and opcode constants already used for stack control.
REQ-032 SHALL place the storage array in sub-module stack_ram: one synchronous write port, one asynchronous read port, no reset.
REQ-033 SHALL keep the pointer, flags and the pop_data/pop_valid registers in return_stack.

Verification
REQ-034 Reset then 3 pushes (0x10, 0x20, 0x30) -> sp=3, empty=0; then 3 pops -> pop_data 0x30, 0x20, 0x10 on consecutive cycles with pop_valid=1; then sp=0 and empty=1.
REQ-035 DEPTH=8: 9 pushes (0x1..0x9) -> sp=8, full=1, overflow=1; next pop -> pop_data=0x8.
REQ-036 Pop on empty -> pop_valid=0, sp=0, underflow=1 and it stays 1 until reset.
REQ-037 Stack holds 0xA, 0xB; push&pop with push_data 0xC -> pop_data=0xB, sp=2; next pop -> 0xC.
REQ-038 sp=5 with flush and push in the same cycle -> sp=0, no write, pop_valid=0.
REQ-039 reset asserted mid-cycle right after a pop is accepted -> pop_valid and sp drop to 0 immediately, with no pop_valid after release.
